// File: rtl/wb32_arbiter2.sv
// -----------------------------------------------------------------------------
// wb32_arbiter2
//
// Two-master, one-slave Wishbone B4 (pipelined) bus arbiter. Master 0 is the
// CPU bus bridge and master 1 a secondary fetch engine (VGA/DMA). The address
// decoder / slave mux downstream sees one master at a time.
//
// Grant policy is round-robin (FIXED_PRIO=0) or master-0-first (FIXED_PRIO=1).
// The grant is registered, so a request from idle is seen on the slave side
// one cycle later. A granted master keeps the bus for as long as it holds
// cyc, so locked cycles and bursts are never split.
//
// A watchdog counts cycles with cyc held and no slave ack. When it expires,
// the arbiter acks the master itself with TIMEOUT_DATA, withholds stb from
// the slave for that cycle and sets a sticky flag.
//
// Parameters:
//   FIXED_PRIO    1 = master 0 wins contention, 0 = round-robin
//   TIMEOUT       cycles without ack before a forced completion (2..65535)
//   TIMEOUT_DATA  read data returned on a forced completion
//
// Ports:
//   I_clk, I_reset_n            clock, asynchronous active-low reset
//   I_mN_cyc/stb/we/adr/sel/dat master N request (N = 0, 1)
//   O_mN_ack/stall/dat          master N response
//   O_s_cyc/stb/we/adr/sel/dat  request towards the slave side
//   I_s_ack/stall/dat           slave response
//   O_grant                     one-hot current grant, 00 = idle
//   O_timeout                   sticky watchdog flag
//   I_timeout_clr               clears O_timeout (a new timeout wins)
// -----------------------------------------------------------------------------
module wb32_arbiter2 #(
    parameter int          FIXED_PRIO   = 0,
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic        I_clk,
    input  logic        I_reset_n,

    input  logic        I_m0_cyc,
    input  logic        I_m0_stb,
    input  logic        I_m0_we,
    input  logic [29:0] I_m0_adr,
    input  logic [3:0]  I_m0_sel,
    input  logic [31:0] I_m0_dat,
    output logic        O_m0_ack,
    output logic        O_m0_stall,
    output logic [31:0] O_m0_dat,

    input  logic        I_m1_cyc,
    input  logic        I_m1_stb,
    input  logic        I_m1_we,
    input  logic [29:0] I_m1_adr,
    input  logic [3:0]  I_m1_sel,
    input  logic [31:0] I_m1_dat,
    output logic        O_m1_ack,
    output logic        O_m1_stall,
    output logic [31:0] O_m1_dat,

    output logic        O_s_cyc,
    output logic        O_s_stb,
    output logic        O_s_we,
    output logic [29:0] O_s_adr,
    output logic [3:0]  O_s_sel,
    output logic [31:0] O_s_dat,
    input  logic        I_s_ack,
    input  logic        I_s_stall,
    input  logic [31:0] I_s_dat,

    output logic [1:0]  O_grant,
    output logic        O_timeout,
    input  logic        I_timeout_clr
);

    // Counter value on which the watchdog fires (it starts at 0 on grant).
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;   // 0 = master 0 was last granted
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_q, timeout_d;
    // Set after a forced completion: the slave may still ack the abandoned
    // access later, and that ack must not reach the master.
    logic        orphan_q, orphan_d;

    logic        granted;
    logic        sel_m1;
    logic        grant_change;
    logic        mx_cyc;
    logic        mx_stb;
    logic        mx_we;
    logic [29:0] mx_adr;
    logic [3:0]  mx_sel;
    logic [31:0] mx_dat;
    logic        fire;
    logic        ack_fwd;
    logic        mx_ack;
    logic [31:0] mx_rdat;

    // ------------------------------------------------------------------------
    // Selection of the granted master
    // ------------------------------------------------------------------------
    assign granted = (state_q != ST_IDLE);
    assign sel_m1  = (state_q == ST_GNT1);

    assign mx_cyc = sel_m1 ? I_m1_cyc : I_m0_cyc;
    assign mx_stb = sel_m1 ? I_m1_stb : I_m0_stb;
    assign mx_we  = sel_m1 ? I_m1_we  : I_m0_we;
    assign mx_adr = sel_m1 ? I_m1_adr : I_m0_adr;
    assign mx_sel = sel_m1 ? I_m1_sel : I_m0_sel;
    assign mx_dat = sel_m1 ? I_m1_dat : I_m0_dat;

    // A real slave ack in the expiry cycle takes precedence over the watchdog.
    assign fire    = granted && mx_cyc && (tmo_cnt_q == TMO_LAST) && !I_s_ack;
    // A late ack for an abandoned access is swallowed until the master
    // presents a new strobe.
    assign ack_fwd = I_s_ack && !(orphan_q && !mx_stb);
    assign mx_ack  = fire || ack_fwd;
    assign mx_rdat = fire ? TIMEOUT_DATA : I_s_dat;

    // ------------------------------------------------------------------------
    // Slave-side request
    // ------------------------------------------------------------------------
    always_comb begin
        O_s_cyc = 1'b0;
        O_s_stb = 1'b0;
        O_s_we  = 1'b0;
        O_s_adr = '0;
        O_s_sel = '0;
        O_s_dat = '0;
        if (granted) begin
            O_s_cyc = mx_cyc;
            O_s_stb = mx_stb && !fire;
            O_s_we  = mx_we;
            O_s_adr = mx_adr;
            O_s_sel = mx_sel;
            O_s_dat = mx_dat;
        end
    end

    // ------------------------------------------------------------------------
    // Master-side responses: a master without the bus sees stall for every
    // strobe it raises, and never an ack.
    // ------------------------------------------------------------------------
    always_comb begin
        O_m0_ack   = 1'b0;
        O_m0_stall = I_m0_stb;
        O_m0_dat   = '0;
        O_m1_ack   = 1'b0;
        O_m1_stall = I_m1_stb;
        O_m1_dat   = '0;
        case (state_q)
            ST_GNT0: begin
                O_m0_ack   = mx_ack;
                O_m0_stall = I_s_stall;
                O_m0_dat   = mx_rdat;
            end
            ST_GNT1: begin
                O_m1_ack   = mx_ack;
                O_m1_stall = I_s_stall;
                O_m1_dat   = mx_rdat;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Grant FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (I_m0_cyc && I_m1_cyc) begin
                    state_d = ((FIXED_PRIO != 0) || last_grant_q) ? ST_GNT0 : ST_GNT1;
                end else if (I_m0_cyc) begin
                    state_d = ST_GNT0;
                end else if (I_m1_cyc) begin
                    state_d = ST_GNT1;
                end
            end
            // Direct handover when the other master is already waiting; the
            // releasing master has dropped cyc, so no priority decision is needed.
            ST_GNT0: begin
                if (!I_m0_cyc) begin
                    state_d = I_m1_cyc ? ST_GNT1 : ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (!I_m1_cyc) begin
                    state_d = I_m0_cyc ? ST_GNT0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Round-robin history, watchdog, sticky flag and orphan tracking
    // ------------------------------------------------------------------------
    always_comb begin
        grant_change = (state_d != state_q);

        last_grant_d = last_grant_q;
        if (grant_change && (state_d == ST_GNT0)) begin
            last_grant_d = 1'b0;
        end else if (grant_change && (state_d == ST_GNT1)) begin
            last_grant_d = 1'b1;
        end

        tmo_cnt_d = tmo_cnt_q;
        if (!granted || grant_change || I_s_ack || fire) begin
            tmo_cnt_d = '0;
        end else if (mx_cyc) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end

        timeout_d = timeout_q;
        if (fire) begin
            timeout_d = 1'b1;
        end else if (I_timeout_clr) begin
            timeout_d = 1'b0;
        end

        orphan_d = orphan_q;
        if (!granted || grant_change) begin
            orphan_d = 1'b0;
        end else if (fire) begin
            orphan_d = 1'b1;
        end else if (mx_stb) begin
            orphan_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State registers. last_grant resets to master 1 so master 0 wins the
    // first contention after reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            tmo_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            orphan_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tmo_cnt_q    <= tmo_cnt_d;
            timeout_q    <= timeout_d;
            orphan_q     <= orphan_d;
        end
    end

    assign O_grant   = {state_q == ST_GNT1, state_q == ST_GNT0};
    assign O_timeout = timeout_q;

endmodule

// File: tb/tb_wb32_arbiter2.sv
// -----------------------------------------------------------------------------
// tb_wb32_arbiter2
//
// Drives one round-robin and one fixed-priority arbiter (both TIMEOUT=8) from
// the same master/slave stimulus. A per-cycle reference model derived from
// the arbitration rules predicts every output of both instances; a vector
// table and hand-written sequences pin down the directed scenarios.
// -----------------------------------------------------------------------------
module tb_wb32_arbiter2;

    localparam int TMO = 8;

    typedef struct packed {
        logic [1:0]  grant;
        logic        s_cyc;
        logic        s_stb;
        logic        s_we;
        logic [29:0] s_adr;
        logic [3:0]  s_sel;
        logic [31:0] s_dat;
        logic        m0_ack;
        logic        m0_stall;
        logic [31:0] m0_dat;
        logic        m1_ack;
        logic        m1_stall;
        logic [31:0] m1_dat;
        logic        tmo;
    } obs_t;

    // inputs c0 s0 c1 s1 ack | grant | ack0 ack1 stall0 stall1 | s_cyc s_stb
    typedef struct packed {
        logic       c0;
        logic       s0;
        logic       c1;
        logic       s1;
        logic       ack;
        logic [1:0] grant;
        logic       ack0;
        logic       ack1;
        logic       st0;
        logic       st1;
        logic       scyc;
        logic       sstb;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        mcyc [2];
    logic        mstb [2];
    logic        mwe  [2];
    logic [29:0] madr [2];
    logic [3:0]  msel [2];
    logic [31:0] mdat [2];
    logic        s_ack;
    logic        s_stall;
    logic [31:0] s_dat;
    logic        clr;

    logic [1:0]  grant_w    [2];
    logic        s_cyc_w    [2];
    logic        s_stb_w    [2];
    logic        s_we_w     [2];
    logic [29:0] s_adr_w    [2];
    logic [3:0]  s_sel_w    [2];
    logic [31:0] s_dat_w    [2];
    logic        m0_ack_w   [2];
    logic        m0_stall_w [2];
    logic [31:0] m0_dat_w   [2];
    logic        m1_ack_w   [2];
    logic        m1_stall_w [2];
    logic [31:0] m1_dat_w   [2];
    logic        tmo_w      [2];

    int nvec  = 0;
    int nfail = 0;

    // Reference model state per instance (index = FIXED_PRIO)
    int m_owner  [2];   // -1 idle, else granted master
    int m_prev   [2];   // master granted most recently
    int m_waited [2];   // cycles waited without ack
    bit m_sticky [2];
    bit m_orphan [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wb32_arbiter2 #(
            .FIXED_PRIO   (g),
            .TIMEOUT      (TMO),
            .TIMEOUT_DATA (32'hDEADBEEF)
        ) u_dut (
            .I_clk         (clk),
            .I_reset_n     (rst_n),
            .I_m0_cyc      (mcyc[0]),
            .I_m0_stb      (mstb[0]),
            .I_m0_we       (mwe[0]),
            .I_m0_adr      (madr[0]),
            .I_m0_sel      (msel[0]),
            .I_m0_dat      (mdat[0]),
            .O_m0_ack      (m0_ack_w[g]),
            .O_m0_stall    (m0_stall_w[g]),
            .O_m0_dat      (m0_dat_w[g]),
            .I_m1_cyc      (mcyc[1]),
            .I_m1_stb      (mstb[1]),
            .I_m1_we       (mwe[1]),
            .I_m1_adr      (madr[1]),
            .I_m1_sel      (msel[1]),
            .I_m1_dat      (mdat[1]),
            .O_m1_ack      (m1_ack_w[g]),
            .O_m1_stall    (m1_stall_w[g]),
            .O_m1_dat      (m1_dat_w[g]),
            .O_s_cyc       (s_cyc_w[g]),
            .O_s_stb       (s_stb_w[g]),
            .O_s_we        (s_we_w[g]),
            .O_s_adr       (s_adr_w[g]),
            .O_s_sel       (s_sel_w[g]),
            .O_s_dat       (s_dat_w[g]),
            .I_s_ack       (s_ack),
            .I_s_stall     (s_stall),
            .I_s_dat       (s_dat),
            .O_grant       (grant_w[g]),
            .O_timeout     (tmo_w[g]),
            .I_timeout_clr (clr)
        );
    end

    function automatic obs_t dut_obs(int d);
        obs_t o;
        o.grant    = grant_w[d];
        o.s_cyc    = s_cyc_w[d];
        o.s_stb    = s_stb_w[d];
        o.s_we     = s_we_w[d];
        o.s_adr    = s_adr_w[d];
        o.s_sel    = s_sel_w[d];
        o.s_dat    = s_dat_w[d];
        o.m0_ack   = m0_ack_w[d];
        o.m0_stall = m0_stall_w[d];
        o.m0_dat   = m0_dat_w[d];
        o.m1_ack   = m1_ack_w[d];
        o.m1_stall = m1_stall_w[d];
        o.m1_dat   = m1_dat_w[d];
        o.tmo      = tmo_w[d];
        return o;
    endfunction

    function automatic bit model_fire(int d);
        int x = m_owner[d];
        if (x < 0) return 1'b0;
        return (mcyc[x] == 1'b1) && (m_waited[d] == TMO - 1) && (s_ack == 1'b0);
    endfunction

    function automatic obs_t model_out(int d);
        obs_t o;
        int x;
        bit fire;
        bit ack;
        logic [31:0] rdat;
        o = '0;
        o.tmo      = m_sticky[d];
        o.m0_stall = mstb[0];
        o.m1_stall = mstb[1];
        x = m_owner[d];
        if (x >= 0) begin
            fire    = model_fire(d);
            o.grant = (x == 0) ? 2'b01 : 2'b10;
            o.s_cyc = mcyc[x];
            o.s_stb = mstb[x] && !fire;
            o.s_we  = mwe[x];
            o.s_adr = madr[x];
            o.s_sel = msel[x];
            o.s_dat = mdat[x];
            ack  = fire || (s_ack && !(m_orphan[d] && !mstb[x]));
            rdat = fire ? 32'hDEADBEEF : s_dat;
            if (x == 0) begin
                o.m0_ack = ack; o.m0_stall = s_stall; o.m0_dat = rdat;
            end else begin
                o.m1_ack = ack; o.m1_stall = s_stall; o.m1_dat = rdat;
            end
        end
        return o;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d]  = -1;
            m_prev[d]   = 1;
            m_waited[d] = 0;
            m_sticky[d] = 1'b0;
            m_orphan[d] = 1'b0;
        end
    endtask

    task automatic model_next();
        for (int d = 0; d < 2; d++) begin
            int x  = m_owner[d];
            int nx;
            bit fire = model_fire(d);
            if (x < 0) begin
                if (mcyc[0] && mcyc[1]) nx = (d == 1) ? 0 : ((m_prev[d] == 0) ? 1 : 0);
                else if (mcyc[0])       nx = 0;
                else if (mcyc[1])       nx = 1;
                else                    nx = -1;
            end else if (mcyc[x])       nx = x;
            else if (mcyc[1 - x])       nx = 1 - x;
            else                        nx = -1;

            if (fire)     m_sticky[d] = 1'b1;
            else if (clr) m_sticky[d] = 1'b0;

            if (x < 0 || nx != x || s_ack || fire) m_waited[d] = 0;
            else if (mcyc[x])                      m_waited[d] = m_waited[d] + 1;

            if (x < 0 || nx != x) m_orphan[d] = 1'b0;
            else if (fire)        m_orphan[d] = 1'b1;
            else if (mstb[x])     m_orphan[d] = 1'b0;

            if (nx >= 0 && nx != x) m_prev[d] = nx;
            m_owner[d] = nx;
        end
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic check_all(string name);
        for (int d = 0; d < 2; d++) begin
            obs_t a = dut_obs(d);
            obs_t e = model_out(d);
            nvec++;
            if (a !== e) begin
                nfail++;
                $display("FAIL model[prio=%0d] %s @%0t: got %h expected %h",
                         d, name, $time, a, e);
            end
        end
    endtask

    // Inputs are applied at posedge+1; outputs are sampled at posedge+4.
    task automatic settle(string name);
        #3;
        check_all(name);
    endtask

    task automatic advance();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            mcyc[i] = 1'b0; mstb[i] = 1'b0; mwe[i] = 1'b0;
            madr[i] = '0;   msel[i] = '0;   mdat[i] = '0;
        end
        s_ack = 1'b0; s_stall = 1'b0; s_dat = '0; clr = 1'b0;
    endtask

    vec_t tbl [13];

    initial begin
        tbl[0]  = 13'b11000_00_0010_00;
        tbl[1]  = 13'b11000_01_0000_11;
        tbl[2]  = 13'b11001_01_1000_11;
        tbl[3]  = 13'b00000_01_0000_00;
        tbl[4]  = 13'b00000_00_0000_00;
        tbl[5]  = 13'b11110_00_0011_00;
        tbl[6]  = 13'b11111_10_0110_11;
        tbl[7]  = 13'b11000_10_0010_00;
        tbl[8]  = 13'b11111_01_1001_11;
        tbl[9]  = 13'b00110_01_0001_00;
        tbl[10] = 13'b11110_10_0010_11;
        tbl[11] = 13'b00000_10_0000_00;
        tbl[12] = 13'b00000_00_0000_00;

        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        chk("reset_grant", 32'(grant_w[0]), 32'h0);
        chk("reset_tmo", 32'(tmo_w[0]), 32'h0);
        rst_n = 1'b1;
        advance();

        // ---- Table: single master, then round-robin handovers ----
        madr[0] = 30'h3FFFFC00;
        madr[1] = 30'h00000155;
        s_dat   = 32'h12345678;
        for (int i = 0; i < 13; i++) begin
            vec_t v = tbl[i];
            vec_t a;
            mcyc[0] = v.c0; mstb[0] = v.s0;
            mcyc[1] = v.c1; mstb[1] = v.s1;
            s_ack   = v.ack;
            settle($sformatf("tbl%0d", i));
            a = v;
            a.grant = grant_w[0];
            a.ack0  = m0_ack_w[0];
            a.ack1  = m1_ack_w[0];
            a.st0   = m0_stall_w[0];
            a.st1   = m1_stall_w[0];
            a.scyc  = s_cyc_w[0];
            a.sstb  = s_stb_w[0];
            chk($sformatf("tbl%0d_outs", i), 32'(a), 32'(v));
            if (v.ack0) chk($sformatf("tbl%0d_dat", i), m0_dat_w[0], 32'h12345678);
            if (v.scyc && v.grant == 2'b01) chk($sformatf("tbl%0d_adr", i), 32'(s_adr_w[0]), 32'h3FFFFC00);
            advance();
        end
        idle_inputs();

        // ---- Watchdog expiry, late ack dropped, sticky flag and clear ----
        mcyc[0] = 1'b1; mstb[0] = 1'b1;
        settle("to_idle"); advance();
        for (int k = 0; k < 8; k++) begin
            settle($sformatf("to_wait%0d", k));
            chk($sformatf("to_grant%0d", k), 32'(grant_w[0]), 32'h1);
            chk($sformatf("to_ack%0d", k), 32'(m0_ack_w[0]), (k == 7) ? 32'h1 : 32'h0);
            if (k == 7) begin
                chk("to_dat", m0_dat_w[0], 32'hDEADBEEF);
                chk("to_sstb", 32'(s_stb_w[0]), 32'h0);
            end
            advance();
        end
        mstb[0] = 1'b0; s_ack = 1'b1;
        settle("to_late");
        chk("to_late_ack_dropped", 32'(m0_ack_w[0]), 32'h0);
        chk("to_flag_set", 32'(tmo_w[0]), 32'h1);
        advance();
        mcyc[0] = 1'b0; s_ack = 1'b0;
        settle("to_rel"); advance();
        settle("to_idle2");
        chk("to_flag_sticky", 32'(tmo_w[0]), 32'h1);
        advance();
        clr = 1'b1;
        settle("to_clr"); advance();
        clr = 1'b0;
        settle("to_cleared");
        chk("to_flag_cleared", 32'(tmo_w[0]), 32'h0);
        advance();

        // ---- Slave ack exactly on the expiry cycle wins ----
        mcyc[0] = 1'b1; mstb[0] = 1'b1;
        settle("bnd_idle"); advance();
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin s_ack = 1'b1; s_dat = 32'hCAFEF00D; end
            settle($sformatf("bnd%0d", k));
            chk($sformatf("bnd_ack%0d", k), 32'(m0_ack_w[0]), (k == 7) ? 32'h1 : 32'h0);
            if (k == 7) chk("bnd_dat", m0_dat_w[0], 32'hCAFEF00D);
            advance();
        end
        idle_inputs();
        settle("bnd_rel");
        chk("bnd_no_flag", 32'(tmo_w[0]), 32'h0);
        advance();
        settle("bnd_idle2"); advance();

        // ---- Master 1 burst holds the bus; async reset mid-burst ----
        mcyc[1] = 1'b1; mstb[1] = 1'b1;
        settle("rb_idle"); advance();
        mcyc[0] = 1'b1; mstb[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle($sformatf("rb%0d", k));
            chk($sformatf("rb_grant%0d", k), 32'(grant_w[0]), 32'h2);
            chk($sformatf("rb_m0_stall%0d", k), 32'(m0_stall_w[0]), 32'h1);
            if (k < 2) advance();
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rb_rst_grant", 32'(grant_w[0]), 32'h0);
        chk("rb_rst_scyc", 32'(s_cyc_w[0]), 32'h0);
        chk("rb_rst_m1_ack", 32'(m1_ack_w[0]), 32'h0);
        check_all("rb_in_reset");
        #1;
        rst_n = 1'b1;
        #1;
        check_all("rb_released");
        advance();
        settle("rb_after");
        chk("rb_first_rr", 32'(grant_w[0]), 32'h1);
        chk("rb_first_fp", 32'(grant_w[1]), 32'h1);
        advance();
        idle_inputs();
        settle("rb_drop"); advance();
        settle("rb_idle3"); advance();

        // ---- Randomized traffic against the reference model ----
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!mcyc[i]) mcyc[i] = ($urandom_range(3) == 0);
                else          mcyc[i] = ($urandom_range(5) != 0);
                mstb[i] = mcyc[i] && $urandom_range(1) == 1;
                mwe[i]  = 1'($urandom);
                madr[i] = 30'($urandom);
                msel[i] = 4'($urandom);
                mdat[i] = $urandom;
            end
            s_ack   = ($urandom_range(9) == 0);
            s_stall = ($urandom_range(3) == 0);
            s_dat   = $urandom;
            clr     = ($urandom_range(39) == 0);
            settle($sformatf("rnd%0d", n));
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
